sd_sector_writer: RTL
=====================

Name: sd_sector_writer

Overview:
- Write-path counterpart to the SD read-back RAM.
- The host fills a 512-byte sector buffer over a byte port, then commits it with a sector address.
- The block then drives the SD controller's write interface (write_start/write_addr/write_data, paced by write_request/write_busy) until the sector is on the card.
- It sits between user logic and sd_ctrl_top's write port and replaces the constant write_finish tie-off with a real completion flag.

Parameters:
- SECTOR_BYTES, 512: buffer depth in bytes; buffer address is 9 bits.
- WORDS, 256: 16-bit words per sector, equal to SECTOR_BYTES/2.
- BUSY_TIMEOUT, 24'd10_000_000: clk cycles allowed in WAIT_BUSY before write_error is raised.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- init_done  in  1  SD card initialised
- we  in  1  host byte write strobe
- waddr  in  9  host byte address
- wdata  in  8  host byte data
- commit  in  1  single-cycle request to write the buffer to sector
- sector  in  32  SD sector address, sampled on accepted commit
- buf_busy  out  1  high from accepted commit until DONE/ERROR is left
- write_finish  out  1  sticky, sector written successfully
- write_error  out  1  sticky, busy timeout or request overrun
- write_start  out  1  single-cycle pulse to the controller
- write_addr  out  32  sector address held stable while buf_busy
- write_data  out  16  current word, {byte[2i], byte[2i+1]}
- write_request  in  1  controller consumed current word (1-cycle pulse)
- write_busy  in  1  controller/card busy

Behaviour:
- Reset (async, reset==0) values:
  - state=IDLE; all outputs 0; word index=0; timeout counter=0.
  - Buffer contents are not cleared.
- Buffer: 512x8 dual-port RAM.
  - Host write when we=1 and buf_busy=0.
  - Writes while buf_busy=1 are ignored.
  - Internal synchronous read, 1-cycle latency.
- FSM:
  - IDLE: commit=1 → latch sector into write_addr; clear write_finish/write_error; buf_busy=1; go to WAIT_INIT. Commit with we in the same cycle: the write is accepted first, then the commit.
  - WAIT_INIT: wait for init_done=1 and write_busy=0, then go to PREFETCH.
  - PREFETCH (2 cycles): read bytes 0,1 and load write_data=word 0; go to START.
  - START: write_start=1 for exactly 1 cycle; go to STREAM.
  - STREAM: on each write_request, index++ and write_data loads the next word by the 2nd cycle after the request. write_request pulses are ≥3 cycles apart.
  - STREAM exit: the 256th request (index reaches WORDS) goes to WAIT_BUSY; write_data holds the last word.
  - WAIT_BUSY: wait for write_busy=0 seen after ≥1 cycle of write_busy=1, or write_busy never rising within 16 cycles → DONE. Counter reaching BUSY_TIMEOUT → ERROR.
  - DONE: write_finish=1; buf_busy=0; go to IDLE.
  - ERROR: write_error=1; buf_busy=0; go to IDLE.
- Boundary rules:
  - Request overrun: a write_request in any state other than STREAM sets write_error without changing state (except in IDLE, where it is ignored).
  - commit while buf_busy=1 is ignored.
  - write_finish/write_error stay set until the next accepted commit.
  - Index is 9 bits wide; comparison is against WORDS, with no wrap into word 0.
  - Mid-operation reset: immediately returns to IDLE, outputs go to 0, write_start cannot glitch.

Test Plan:
- Reset then fill: reset low 5 cycles, fill buffer byte[n]=n[7:0], commit with sector=32'h0000_0100, init_done=1 → one write_start pulse; write_addr=0x100; 256 write_request pulses yield write_data 0x0001, 0x0203 … 0xFEFF; write_busy 1→0 → write_finish=1, buf_busy=0.
- Init gating: commit while init_done=0 for 1000 cycles → no write_start. Raise init_done → write_start 3 cycles later (2 PREFETCH + START).
- Locked buffer: during STREAM, host writes byte[0]=0xAA → ignored. Next commit sector 5 streams the original word 0 (0x0001).
- Timeout: BUSY_TIMEOUT=100, write_busy held 1 after the last request → write_error=1 at cycle 100, write_finish=0, buf_busy=0.
- Overrun: extra write_request in WAIT_BUSY → write_error=1. Following commit clears both flags.
- Mid-stream reset: reset low at word 77 → all outputs 0. Re-commit restarts from word 0 with one write_start.

Source files
------------

// File: rtl/sd_sector_writer.sv
// Sector write buffer: host fills 512 bytes, commit streams them as 256 words to the SD controller write port.
// Word load 2 cycles after each write_request; host writes and commits are ignored while buf_busy.
module sd_sector_writer #(
  parameter int          SECTOR_BYTES = 512,
  parameter int          WORDS        = 256,
  parameter logic [23:0] BUSY_TIMEOUT = 24'd10_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_init_done,
  input  logic        i_we,
  input  logic [8:0]  i_waddr,
  input  logic [7:0]  i_wdata,
  input  logic        i_commit,
  input  logic [31:0] i_sector,
  output logic        o_buf_busy,
  output logic        o_write_finish,
  output logic        o_write_error,
  output logic        o_write_start,
  output logic [31:0] o_write_addr,
  output logic [15:0] o_write_data,
  input  logic        i_write_request,
  input  logic        i_write_busy
);

  localparam int         HALF   = SECTOR_BYTES / 2;
  localparam logic [8:0] L_LAST = 9'(WORDS);

  typedef enum logic [2:0] {
    IDLE, WAIT_INIT, PREFETCH, START, STREAM, WAIT_BUSY, DONE, ERROR
  } state_t;

  state_t      r_state, w_next;
  logic [8:0]  r_idx;
  logic [23:0] r_tmo;
  logic        r_seen_busy;
  logic        r_pf;
  logic        r_load;
  logic [15:0] r_rd_word;
  logic [7:0]  r_mem_hi [HALF];
  logic [7:0]  r_mem_lo [HALF];

  logic        w_rd_en;
  logic [7:0]  w_raddr;
  logic [8:0]  w_idx_inc;
  logic        w_host_we;
  logic        w_accept;
  logic        w_overrun;

  assign w_idx_inc = r_idx + 9'd1;
  assign w_host_we = i_we && !o_buf_busy;
  assign w_accept  = (r_state == IDLE) && i_commit;
  assign w_overrun = i_write_request && (r_state != IDLE) && (r_state != STREAM);

  // Even bytes form the high half of each word, odd bytes the low half.
  always_ff @(posedge i_clk) begin
    if (w_host_we) begin
      if (i_waddr[0]) r_mem_lo[i_waddr[8:1]] <= i_wdata;
      else            r_mem_hi[i_waddr[8:1]] <= i_wdata;
    end
    if (w_rd_en) r_rd_word <= {r_mem_hi[w_raddr], r_mem_lo[w_raddr]};
  end

  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    w_raddr = r_idx[7:0];
    case (r_state)
      IDLE:      if (i_commit) w_next = WAIT_INIT;
      WAIT_INIT: if (i_init_done && !i_write_busy) w_next = PREFETCH;
      PREFETCH: begin
        if (!r_pf) begin
          w_rd_en = 1'b1;
          w_raddr = 8'd0;
        end else begin
          w_next = START;
        end
      end
      START:     w_next = STREAM;
      STREAM: begin
        if (i_write_request) begin
          if (w_idx_inc == L_LAST) begin
            w_next = WAIT_BUSY;
          end else begin
            w_rd_en = 1'b1;
            w_raddr = w_idx_inc[7:0];
          end
        end
      end
      WAIT_BUSY: begin
        if (r_tmo == BUSY_TIMEOUT - 24'd1)               w_next = ERROR;
        else if (r_seen_busy && !i_write_busy)           w_next = DONE;
        // Card that never signals busy still completes after a short grace window.
        else if (!r_seen_busy && !i_write_busy && r_tmo == 24'd15) w_next = DONE;
      end
      DONE:      w_next = IDLE;
      ERROR:     w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= IDLE;
      r_idx          <= 9'd0;
      r_tmo          <= 24'd0;
      r_seen_busy    <= 1'b0;
      r_pf           <= 1'b0;
      r_load         <= 1'b0;
      o_buf_busy     <= 1'b0;
      o_write_finish <= 1'b0;
      o_write_error  <= 1'b0;
      o_write_start  <= 1'b0;
      o_write_addr   <= 32'd0;
      o_write_data   <= 16'd0;
    end else begin
      r_state       <= w_next;
      r_load        <= w_rd_en;
      r_pf          <= (r_state == PREFETCH) ? ~r_pf : 1'b0;
      o_write_start <= (w_next == START);
      if (r_load) o_write_data <= r_rd_word;

      if (r_state == WAIT_BUSY) begin
        r_tmo <= r_tmo + 24'd1;
        if (i_write_busy) r_seen_busy <= 1'b1;
      end else begin
        r_tmo       <= 24'd0;
        r_seen_busy <= 1'b0;
      end

      if (w_accept) begin
        r_idx          <= 9'd0;
        o_write_addr   <= i_sector;
        o_write_finish <= 1'b0;
        o_write_error  <= 1'b0;
        o_buf_busy     <= 1'b1;
      end else if (r_state == STREAM && i_write_request) begin
        r_idx <= w_idx_inc;
      end

      if (r_state == DONE) begin
        o_write_finish <= 1'b1;
        o_buf_busy     <= 1'b0;
      end
      if (r_state == ERROR) begin
        o_write_error <= 1'b1;
        o_buf_busy    <= 1'b0;
      end
      if (w_overrun) o_write_error <= 1'b1;
    end
  end

endmodule
